// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain controller of the asynchronous FIFO.
// Owns the read pointer and synchronizes the write pointer into rd_clk.
// Derives EMPTY and the fill level from the two pointers.
// Issues reads to the synchronous-read memory and presents a first-word-fall-through
// stream through a 2-entry output buffer.
// Optional feature: define FIFO_RD_ALMOST_EMPTY_EN to build the almost_empty output.
//
// Output buffer occupancy FSM:
//   state   | meaning
//   B_EMPTY | buffer holds no word, dout_valid low
//   B_ONE   | one word buffered, held in the head entry
//   B_TWO   | two words buffered, head entry plus tail entry

module fifo_rd_ctrl #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int AE_THRESH = 2,
    localparam int PB       = $clog2(DEPTH)
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic [PB:0]      wr_ptr_gray_async,
    output logic [PB:0]      rd_ptr_gray,
    output logic             mem_rd_en,
    output logic [PB-1:0]    mem_rd_addr,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             EMPTY,
    output logic [PB:0]      rd_level
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    output logic             almost_empty
`endif
);

    typedef enum logic [1:0] {
        B_EMPTY = 2'd0,
        B_ONE   = 2'd1,
        B_TWO   = 2'd2
    } buf_state_e;

    logic [PB:0]      wr_sync1_q;
    logic [PB:0]      wr_sync2_q;
    logic [PB:0]      wr_sync_bin;
    logic [PB:0]      rd_ptr_q;
    logic [PB:0]      rd_ptr_d;
    logic [PB:0]      rd_gray_q;
    logic             pend_q;
    buf_state_e       state_q;
    buf_state_e       state_d;
    logic [WIDTH-1:0] buf0_q;
    logic [WIDTH-1:0] buf0_d;
    logic [WIDTH-1:0] buf1_q;
    logic [WIDTH-1:0] buf1_d;
    logic [1:0]       buf_cnt;
    logic [1:0]       occ_next;
    logic             pop;
    logic             empty_w;
    logic             rd_en_w;
    logic [PB:0]      level_w;

    // Two-flop synchronizer bringing the Gray write pointer into rd_clk.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wr_sync1_q <= '0;
            wr_sync2_q <= '0;
        end else begin
            wr_sync1_q <= wr_ptr_gray_async;
            wr_sync2_q <= wr_sync1_q;
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wr_sync_bin = '0;
        for (int i = 0; i <= PB; i++) begin
            wr_sync_bin[i] = ^(wr_sync2_q >> i);
        end
    end

    // Pointer comparison, buffer bookkeeping and read issue decision.
    always_comb begin
        empty_w  = (wr_sync_bin == rd_ptr_q);
        level_w  = wr_sync_bin - rd_ptr_q;
        buf_cnt  = state_q;
        pop      = (state_q != B_EMPTY) && dout_ready;
        // pop only happens with at least one word buffered, so this cannot underflow
        occ_next = buf_cnt + {1'b0, pend_q} - {1'b0, pop};
        rd_en_w  = !empty_w && (occ_next <= 2'd1);
        rd_ptr_d = rd_ptr_q + {{PB{1'b0}}, rd_en_w};
    end

    // Occupancy transitions and buffer data movement; the head entry is always dout.
    always_comb begin
        state_d = state_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case (state_q)
            B_EMPTY: begin
                if (pend_q) begin
                    buf0_d  = mem_rd_data;
                    state_d = B_ONE;
                end
            end
            B_ONE: begin
                if (pend_q && pop) begin
                    buf0_d = mem_rd_data;
                end else if (pend_q) begin
                    buf1_d  = mem_rd_data;
                    state_d = B_TWO;
                end else if (pop) begin
                    state_d = B_EMPTY;
                end
            end
            B_TWO: begin
                if (pop) begin
                    buf0_d = buf1_q;
                    if (pend_q) begin
                        buf1_d = mem_rd_data;
                    end else begin
                        state_d = B_ONE;
                    end
                end
            end
            default: begin
                state_d = B_EMPTY;
            end
        endcase
    end

    // Read pointer, registered Gray copy, in-flight flag and output buffer.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_ptr_q  <= '0;
            rd_gray_q <= '0;
            pend_q    <= 1'b0;
            state_q   <= B_EMPTY;
            buf0_q    <= '0;
            buf1_q    <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            // Gray is built from the next pointer so the register toggles one bit per increment.
            rd_gray_q <= rd_ptr_d ^ (rd_ptr_d >> 1);
            pend_q    <= rd_en_w;
            state_q   <= state_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
        end
    end

    // Output drive.
    always_comb begin
        rd_ptr_gray = rd_gray_q;
        mem_rd_en   = rd_en_w;
        mem_rd_addr = rd_ptr_q[PB-1:0];
        dout        = buf0_q;
        dout_valid  = (state_q != B_EMPTY);
        EMPTY       = empty_w;
        rd_level    = level_w;
    end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic [PB+1:0] ae_total;

    // Words still to be delivered: unread memory words plus buffered words.
    always_comb begin
        ae_total     = {1'b0, level_w} + {{PB{1'b0}}, buf_cnt};
        almost_empty = (ae_total <= (PB+2)'(AE_THRESH));
    end
`else
    // The threshold only matters when the almost-empty output is built in.
    logic unused_ae_thresh;
    assign unused_ae_thresh = ^AE_THRESH;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl (DEPTH=8, WIDTH=8).
// Models the write side and the synchronous-read memory, and checks the stream against a queue of written words.
// almost_empty checks are built only when FIFO_RD_ALMOST_EMPTY_EN is defined.
`timescale 1ns/1ps

module tb_fifo_rd_ctrl;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int PB    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [PB:0]      wr_gray;
    logic [PB:0]      rd_ptr_gray;
    logic             mem_rd_en;
    logic [PB-1:0]    mem_rd_addr;
    logic [WIDTH-1:0] mem_rd_data;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             EMPTY;
    logic [PB:0]      rd_level;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic             almost_empty;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PB:0]      wr_bin;
    logic [WIDTH-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int issued, pops, valid_cycles, first_pop, last_pop;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AE_THRESH(2)) dut (
        .rd_clk            (clk),
        .rd_rst_n          (rst_n),
        .wr_ptr_gray_async (wr_gray),
        .rd_ptr_gray       (rd_ptr_gray),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_data       (mem_rd_data),
        .dout              (dout),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .EMPTY             (EMPTY),
        .rd_level          (rd_level)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        ,
        .almost_empty      (almost_empty)
`endif
    );

    // Synchronous-read memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    function automatic logic [PB:0] bin2gray(input logic [PB:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write one word into the memory model and advance the write pointer.
    task automatic put(input logic [WIDTH-1:0] v);
        mem[wr_bin[PB-1:0]] = v;
        exp_q.push_back(v);
        wr_bin  = wr_bin + 1'b1;
        wr_gray = bin2gray(wr_bin);
    endtask

    // One clock: pre-edge stream checks, edge, post-edge pointer/hold checks.
    task automatic tick();
        logic [PB:0]      g_prev;
        logic [WIDTH-1:0] d_prev;
        logic             hold;
        #1;
        chk("rd_while_empty", {31'd0, mem_rd_en & EMPTY}, 0);
        if (dout_valid) valid_cycles++;
        if (mem_rd_en) issued++;
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_extra", 1, 0);
            end else begin
                chk("stream_data", {24'd0, dout}, {24'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        hold   = dout_valid && !dout_ready;
        d_prev = dout;
        g_prev = rd_ptr_gray;
        @(posedge clk);
        #1;
        cyc++;
        chk("gray_one_bit", {31'd0, ($countones(rd_ptr_gray ^ g_prev) <= 1)}, 1);
        if (hold) begin
            chk("hold_valid", {31'd0, dout_valid}, 1);
            chk("hold_data", {24'd0, dout}, {24'd0, d_prev});
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        dout_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
        tick();
        tick();
    endtask

    initial begin
        int ae_exp [5];
        rst_n      = 1'b0;
        wr_bin     = '0;
        wr_gray    = 4'b0110;
        dout_ready = 1'b0;
        issued = 0; pops = 0; valid_cycles = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset with a garbage write pointer on the input.
        repeat (3) tick();
        chk("rst_gray", {28'd0, rd_ptr_gray}, 0);
        chk("rst_dout", {24'd0, dout}, 0);
        chk("rst_valid", {31'd0, dout_valid}, 0);
        chk("rst_empty", {31'd0, EMPTY}, 1);
        chk("rst_level", {28'd0, rd_level}, 0);
        chk("rst_rden", {31'd0, mem_rd_en}, 0);
        chk("rst_addr", {29'd0, mem_rd_addr}, 0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        chk("rst_ae", {31'd0, almost_empty}, 1);
`endif
        wr_gray = bin2gray(wr_bin);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_empty", {31'd0, EMPTY}, 1);
            chk("idle_rden", {31'd0, mem_rd_en}, 0);
        end

        // Single word: fill latency.
        dout_ready = 1'b1;
        pops = 0;
        put(8'h5A);
        tick();
        chk("sw_e1_empty", {31'd0, EMPTY}, 1);
        tick();
        chk("sw_e2_empty", {31'd0, EMPTY}, 0);
        chk("sw_e2_rden", {31'd0, mem_rd_en}, 1);
        chk("sw_e2_addr", {29'd0, mem_rd_addr}, 0);
        chk("sw_e2_level", {28'd0, rd_level}, 1);
        tick();
        chk("sw_e3_valid", {31'd0, dout_valid}, 0);
        chk("sw_e3_gray", {28'd0, rd_ptr_gray}, 1);
        chk("sw_e3_empty", {31'd0, EMPTY}, 1);
        tick();
        chk("sw_e4_valid", {31'd0, dout_valid}, 1);
        chk("sw_e4_dout", {24'd0, dout}, 32'h5A);
        tick();
        chk("sw_e5_valid", {31'd0, dout_valid}, 0);
        chk("sw_pops", pops, 1);

        // Burst of 8 with ready high: back-to-back delivery.
        pops = 0; valid_cycles = 0; first_pop = -1;
        for (int i = 0; i < 8; i++) begin
            put(8'(8'h10 + i));
            tick();
        end
        drain(40);
        chk("burst_pops", pops, 8);
        chk("burst_span", last_pop - first_pop, 7);
        chk("burst_valid_cycles", valid_cycles, 8);
        chk("burst_empty", {31'd0, EMPTY}, 1);
        chk("burst_level", {28'd0, rd_level}, 0);
        chk("burst_gray", {28'd0, rd_ptr_gray}, {28'd0, bin2gray(wr_bin)});

        // Backpressure: 8 words, consumer stalled.
        dout_ready = 1'b0;
        issued = 0; pops = 0;
        for (int i = 0; i < 8; i++) begin
            put(8'(8'h30 + i));
            tick();
        end
        repeat (6) tick();
        chk("bp_issued", issued, 2);
        chk("bp_level", {28'd0, rd_level}, 6);
        chk("bp_valid", {31'd0, dout_valid}, 1);
        chk("bp_dout", {24'd0, dout}, 32'h30);
        chk("bp_rden", {31'd0, mem_rd_en}, 0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        chk("bp_ae", {31'd0, almost_empty}, 0);
`endif
        drain(40);
        chk("bp_pops", pops, 8);
        chk("bp_empty", {31'd0, EMPTY}, 1);
        chk("bp_level_end", {28'd0, rd_level}, 0);

        // Wrap-around: three full bursts, the middle one with a random ready pattern.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) begin
                put(8'(8'h40 + b * 16 + i));
                dout_ready = (b == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                tick();
            end
            drain(60);
            chk($sformatf("wrap%0d_empty", b), {31'd0, EMPTY}, 1);
            chk($sformatf("wrap%0d_level", b), {28'd0, rd_level}, 0);
            chk($sformatf("wrap%0d_gray", b), {28'd0, rd_ptr_gray}, {28'd0, bin2gray(wr_bin)});
        end

        // Four words at once, then reset mid-stream.
        dout_ready = 1'b1;
        ae_exp[0] = 1; ae_exp[1] = 0; ae_exp[2] = 0; ae_exp[3] = 0; ae_exp[4] = 1;
        for (int i = 0; i < 4; i++) put(8'(8'h70 + i));
        for (int e = 0; e < 5; e++) begin
            tick();
            if (e == 1) chk("ae_e2_empty", {31'd0, EMPTY}, 0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
            chk($sformatf("ae_edge%0d", e + 1), {31'd0, almost_empty}, ae_exp[e]);
`endif
        end
        chk("mid_valid_before", {31'd0, dout_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, dout_valid}, 0);
        chk("mid_rst_empty", {31'd0, EMPTY}, 1);
        chk("mid_rst_level", {28'd0, rd_level}, 0);
        chk("mid_rst_gray", {28'd0, rd_ptr_gray}, 0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        chk("mid_rst_ae", {31'd0, almost_empty}, 1);
`endif
        exp_q.delete();
        wr_bin  = '0;
        wr_gray = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", {31'd0, EMPTY}, 1);

        // Recovery after reset: one word from address 0.
        pops = 0;
        put(8'hC3);
        drain(20);
        chk("recover_pops", pops, 1);
        chk("recover_empty", {31'd0, EMPTY}, 1);
        chk("recover_gray", {28'd0, rd_ptr_gray}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-domain controller for the asynchronous FIFO. It owns the read pointer, synchronizes the write pointer into `rd_clk`, derives EMPTY and the fill level, and sequences reads from the synchronous-read FIFO memory. It presents a first-word-fall-through valid/ready stream to the consumer through a 2-entry output buffer, so reads sustain one word per cycle.

## Interface
- `DEPTH`, 8: FIFO memory depth in words; power of two, ≥4. `PB = $clog2(DEPTH)`.
- `WIDTH`, 8: data word width.
- `AE_THRESH`, 2: almost-empty threshold in words. Used only with `FIFO_RD_ALMOST_EMPTY_EN`.

Ports:
- `rd_clk` in 1: read clock. Single clock; all logic is on its rising edge.
- `rd_rst_n` in 1: asynchronous, active-low reset.
- `wr_ptr_gray_async` in PB+1: write pointer, Gray coded, from the write domain (unsynchronized).
- `rd_ptr_gray` out PB+1: registered Gray read pointer, for the write domain.
- `mem_rd_en` out 1: memory read strobe.
- `mem_rd_addr` out PB: memory read address, `rd_ptr[PB-1:0]`.
- `mem_rd_data` in WIDTH: memory read data, valid the cycle after `mem_rd_en` is sampled.
- `dout` out WIDTH: head-of-stream data.
- `dout_valid` out 1: `dout` holds a word.
- `dout_ready` in 1: consumer accepts `dout`.
- `EMPTY` out 1: no unread words remain in the memory, as seen in the read domain.
- `rd_level` out PB+1: words in the memory not yet read (output buffer excluded).
- `almost_empty` out 1: present only with `FIFO_RD_ALMOST_EMPTY_EN`.

## Operation
- **Write-pointer synchronizer:** 2-flop synchronizer on `wr_ptr_gray_async`, output `wr_sync_gray`.
- **Empty and level:** `wr_sync_gray` is converted Gray→binary combinationally to `wr_sync_bin`.
  - `EMPTY = (wr_sync_bin == rd_ptr)`, comparing all PB+1 bits including the wrap bit.
  - `rd_level = wr_sync_bin - rd_ptr`, modulo 2^(PB+1). It never exceeds DEPTH.
- **Read pointer:** `rd_ptr` is PB+1-bit binary and increments by 1 on every cycle with `mem_rd_en=1`. It wraps from 2·DEPTH-1 to 0.
  - `rd_ptr_gray` is registered from the binary-to-Gray value of the next `rd_ptr`, so it changes one bit per increment and never glitches.
- **Output buffer:** 2-entry FIFO, `buf_cnt` 0..2. `dout` is the head entry; `dout_valid = (buf_cnt != 0)`.
  - `pend` = a read was issued last cycle and its data lands this cycle.
  - `pop = dout_valid & dout_ready`.
- **Occupancy FSM**, states on `buf_cnt`: `B_EMPTY` (0), `B_ONE` (1), `B_TWO` (2).
  - Next `buf_cnt = buf_cnt + pend - pop`.
  - Transitions: `B_EMPTY`→`B_ONE` on `pend`. `B_ONE`→`B_TWO` on `pend & !pop`. `B_ONE`→`B_EMPTY` on `!pend & pop`. `B_TWO`→`B_ONE` on `pop & !pend`. All other combinations hold the state.
  - A simultaneous landing and pop in `B_TWO` keeps `B_TWO`.
- **Issue rule:** `mem_rd_en = !EMPTY & (buf_cnt + pend - pop <= 1)`.
  - This guarantees the buffer never overflows and sustains 1 word per cycle when `dout_ready` stays high.
  - `mem_rd_en` is never asserted while EMPTY=1.
- **Hold rules:**
  - `dout` stays stable while `dout_valid & !dout_ready`.
  - Words leave the buffer in write order.

## Timing
- **Reset values:**
  - Outputs: `rd_ptr_gray=0`, `dout=0`, `dout_valid=0`, `EMPTY=1`, `rd_level=0`, `mem_rd_en=0`, `mem_rd_addr=0`, `almost_empty=1`.
  - Internal: `rd_ptr=0`, `pend=0`, `buf_cnt=0`, synchronizer flops 0.
- **Fill latency:** with the FIFO empty and `wr_ptr_gray_async` advancing by 1:
  - EMPTY falls after rd_clk edge 2.
  - `mem_rd_en` is high in that same cycle.
  - `dout_valid` rises after edge 4.
- **Throughput:** 1 word per cycle while `rd_level>0` and `dout_ready=1`.
- **Backpressure:** at most 2 words are buffered. Reads stop while `buf_cnt + pend - pop > 1`.
- **Reset mid-operation:** `rd_rst_n` low clears all state immediately. Buffered and in-flight words are discarded, and the write domain must be reset together with this block.
- **Pointers:** EMPTY and `rd_level` are pessimistic (synchronized `wr_ptr` lags). They are never optimistic.

## Configuration
- **`FIFO_RD_ALMOST_EMPTY_EN` defined:**
  - `almost_empty` port exists.
  - `almost_empty = (rd_level + buf_cnt) <= AE_THRESH`, combinational.
  - Reset value 1.
- **`FIFO_RD_ALMOST_EMPTY_EN` undefined:** the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rd_rst_n=0` with `wr_ptr_gray_async=3'b...` random → all outputs at reset values; release with `wr_ptr_gray_async=0` → EMPTY stays 1, `mem_rd_en` never 1.
- **Single word:** `wr_ptr_gray_async` 0→1 (DEPTH=8), `dout_ready=1` → EMPTY low after edge 2; `dout_valid` high after edge 4 for one cycle with `dout=mem[0]`; `rd_ptr_gray`=1.
- **Burst:** `wr_ptr_gray_async` steps to gray(8), `dout_ready=1` → 8 consecutive `dout_valid` cycles carrying `mem[0..7]` in order; afterwards EMPTY=1, `rd_level=0`.
- **Backpressure:** 8 words available, `dout_ready=0` → `buf_cnt` saturates at 2, `mem_rd_en` issued exactly twice, `rd_level=6`; raise ready → remaining words stream in order without loss or duplication.
- **Wrap-around:** run 3 full bursts of 8 → `rd_ptr` passes 15→0; EMPTY correct at each boundary, and `rd_ptr_gray` changes one bit per increment (checked every cycle).
- **Almost-empty (macro on, AE_THRESH=2):** 4 words available, ready=1 → `almost_empty` goes 1→0 as the level rises above 2, then back to 1 as total remaining drops to 2; mid-stream `rd_rst_n` pulse → `dout_valid=0` and EMPTY=1 immediately.
